// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DW    = 32;
    localparam int unsigned ZERO_REG = 0;

    // Load queue record at the default widths.
    typedef struct packed {
        logic             live;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_queue.sv
// Load-result FIFO with per-entry WAW kill and pending-register scoreboard.
module rf_wb_queue
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = RF_AW,
    parameter int unsigned DW    = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] rd1,
    input  logic [AW-1:0] rd2,
    output logic          full,
    output logic          empty,
    output logic          head_live,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          busy1,
    output logic          busy2
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic          live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          hit1, hit2;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign head_live = mem_q[rptr_q[PW-1:0]].live;
    assign head_addr = mem_q[rptr_q[PW-1:0]].addr;
    assign head_data = mem_q[rptr_q[PW-1:0]].data;

    // Kill first, then push, so a load enqueued alongside the ALU write survives.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill && (mem_q[PW'(i)].addr == kill_addr)) begin
                mem_d[PW'(i)].live = 1'b0;
            end
        end
        if (pop) begin
            mem_d[rptr_q[PW-1:0]].live = 1'b0;
            rptr_d = rptr_q + 1'b1;
        end
        if (push) begin
            mem_d[wptr_q[PW-1:0]] = '{live: 1'b1, addr: push_addr, data: push_data};
            wptr_d = wptr_q + 1'b1;
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit1 |= mem_q[PW'(i)].live && (mem_q[PW'(i)].addr == rd1);
            hit2 |= mem_q[PW'(i)].live && (mem_q[PW'(i)].addr == rd2);
        end
        busy1 = hit1 && (rd1 != AW'(ZERO_REG));
        busy2 = hit2 && (rd2 != AW'(ZERO_REG));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[PW'(i)] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port sequencer: ALU writes win, queued loads drain in idle cycles.
// Optional RF_WB_BYPASS_EN adds fwd_* ports and masks busy for the address being written.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = RF_DW,
    parameter int unsigned AW    = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wr,
    input  logic [DW-1:0] alu_wd,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_wr,
    input  logic [DW-1:0] ld_wd,
    input  logic [AW-1:0] rD1,
    input  logic [AW-1:0] rD2,
    output logic          busy1,
    output logic          busy2,
`ifdef RF_WB_BYPASS_EN
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          we,
    output logic [AW-1:0] wR,
    output logic [DW-1:0] wD
);

    logic          q_full, q_empty, q_head_live, q_busy1, q_busy2;
    logic [AW-1:0] q_head_addr;
    logic [DW-1:0] q_head_data;
    logic          alu_issue, push, pop;
    logic          we_q, we_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [DW-1:0] wd_q, wd_d;

    assign alu_issue = alu_valid && (alu_wr != AW'(ZERO_REG));
    assign ld_ready  = !rst && !q_full;
    // Loads to the zero register are consumed without being queued.
    assign push      = ld_valid && ld_ready && (ld_wr != AW'(ZERO_REG));
    assign pop       = !alu_issue && !q_empty;

    rf_wb_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (ld_wr),
        .push_data (ld_wd),
        .pop       (pop),
        .kill      (alu_issue),
        .kill_addr (alu_wr),
        .rd1       (rD1),
        .rd2       (rD2),
        .full      (q_full),
        .empty     (q_empty),
        .head_live (q_head_live),
        .head_addr (q_head_addr),
        .head_data (q_head_data),
        .busy1     (q_busy1),
        .busy2     (q_busy2)
    );

    always_comb begin
        we_d = 1'b0;
        wr_d = '0;
        wd_d = '0;
        if (alu_issue) begin
            we_d = 1'b1;
            wr_d = alu_wr;
            wd_d = alu_wd;
        end else if (pop && q_head_live) begin
            we_d = 1'b1;
            wr_d = q_head_addr;
            wd_d = q_head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            wr_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            wr_q <= wr_d;
            wd_q <= wd_d;
        end
    end

    assign we = we_q;
    assign wR = wr_q;
    assign wD = wd_q;

`ifdef RF_WB_BYPASS_EN
    assign fwd_valid = we_q;
    assign fwd_addr  = wr_q;
    assign fwd_data  = wd_q;
    assign busy1     = q_busy1 && !(we_q && (wr_q == rD1));
    assign busy2     = q_busy2 && !(we_q && (wr_q == rD2));
`else
    assign busy1     = q_busy1;
    assign busy2     = q_busy2;
`endif

endmodule
